fnv1a_seq_ctrl: RTL and testbench



---
 rtl/fnv1a_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fnv1a_seq_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fnv1a_seq_ctrl.sv
// rtl/fnv1a_seq_ctrl.sv - byte-serial FNV-1a 32-bit hash sequencer with MSB-first digest readout
// Optional FNV_FAST_MUL_EN: single-cycle multiply per DATA byte instead of the 5-cycle shift-add MUL state.
module fnv1a_seq_ctrl #(
   parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_byte,
   output logic        out_last,
   output logic        busy,
   output logic [31:0] hash
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   localparam logic [1:0] OP_DATA   = 2'b00;
   localparam logic [1:0] OP_FINISH = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_hash;
   logic [31:0] r_snap;
   logic [1:0]  r_idx;
   logic        w_cmd_acc;
   logic        w_out_hs;
   logic [31:0] w_x_new;

`ifndef FNV_FAST_MUL_EN
   logic [31:0] r_x;
   logic [31:0] r_acc;
   logic [2:0]  r_step;
   logic [31:0] w_term;

   // One shifted copy of x per MUL cycle; the x<<0 term is seeded into acc at accept.
   always_comb begin
      w_term = r_x << 24;
      case (r_step)
         3'd0:    w_term = r_x << 1;
         3'd1:    w_term = r_x << 4;
         3'd2:    w_term = r_x << 7;
         3'd3:    w_term = r_x << 8;
         default: w_term = r_x << 24;
      endcase
   end
`endif

   assign w_cmd_acc = cmd_valid && (r_state == S_IDLE);
   assign w_out_hs  = (r_state == S_OUT) && out_ready;
   assign w_x_new   = r_hash ^ {24'h0, cmd_data};

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = (r_state == S_OUT);
   assign out_last  = (r_state == S_OUT) && (r_idx == 2'd3);
   assign out_byte  = r_snap[31:24];
   assign hash      = r_hash;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_acc) begin
               if (cmd_op == OP_FINISH) begin
                  w_state_nxt = S_OUT;
`ifndef FNV_FAST_MUL_EN
               end else if (cmd_op == OP_DATA) begin
                  w_state_nxt = S_MUL;
`endif
               end
            end
         end
`ifndef FNV_FAST_MUL_EN
         S_MUL: begin
            if (r_step == 3'd4) begin
               w_state_nxt = S_IDLE;
            end
         end
`endif
         S_OUT: begin
            if (w_out_hs && (r_idx == 2'd3)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hash <= OFFSET_BASIS;
         r_snap <= 32'h0;
         r_idx  <= 2'd0;
`ifndef FNV_FAST_MUL_EN
         r_x    <= 32'h0;
         r_acc  <= 32'h0;
         r_step <= 3'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cmd_acc) begin
                  case (cmd_op)
                     OP_DATA: begin
`ifdef FNV_FAST_MUL_EN
                        r_hash <= w_x_new + (w_x_new << 1) + (w_x_new << 4)
                                + (w_x_new << 7) + (w_x_new << 8) + (w_x_new << 24);
`else
                        r_x    <= w_x_new;
                        r_acc  <= w_x_new;
                        r_step <= 3'd0;
`endif
                     end
                     OP_FINISH: begin
                        r_snap <= r_hash;
                        r_idx  <= 2'd0;
                     end
                     OP_CLEAR: r_hash <= OFFSET_BASIS;
                     default: ;
                  endcase
               end
            end
`ifndef FNV_FAST_MUL_EN
            S_MUL: begin
               if (r_step == 3'd4) begin
                  r_hash <= r_acc + w_term;
               end else begin
                  r_acc  <= r_acc + w_term;
                  r_step <= r_step + 3'd1;
               end
            end
`endif
            S_OUT: begin
               // Shift zeros in so out_byte settles to 0 once the digest is drained.
               if (w_out_hs) begin
                  r_snap <= {r_snap[23:0], 8'h00};
                  r_idx  <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     r_hash <= OFFSET_BASIS;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fnv1a_seq_ctrl.sv
// tb/tb_fnv1a_seq_ctrl.sv - randomized self-checking bench for fnv1a_seq_ctrl against an arithmetic FNV-1a model
module tb_fnv1a_seq_ctrl;

   localparam logic [31:0] OB    = 32'h811C9DC5;
   localparam logic [31:0] PRIME = 32'h01000193;
`ifdef FNV_FAST_MUL_EN
   localparam int MUL_LAT = 0;
`else
   localparam int MUL_LAT = 5;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = 2'b00;
   logic [7:0]  cmd_data = 8'h00;
   logic        out_ready = 1'b0;
   logic        cmd_ready;
   logic        out_valid;
   logic [7:0]  out_byte;
   logic        out_last;
   logic        busy;
   logic [31:0] hash;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_hash = OB;
   logic [7:0]  exp_q[$];
   logic [31:0] last_digest = 32'h0;
   logic        pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [7:0]  foobar[6] = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};

   fnv1a_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_byte  (out_byte),
      .out_last  (out_last),
      .busy      (busy),
      .hash      (hash)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_cmd(input logic [1:0] op, input logic [7:0] d);
      case (op)
         2'b00: m_hash = (m_hash ^ {24'h0, d}) * PRIME;
         2'b01: begin
            for (int i = 3; i >= 0; i--) exp_q.push_back(m_hash[8*i +: 8]);
            m_hash = OB;
         end
         2'b10: m_hash = OB;
         default: ;
      endcase
   endtask

   // Called at a negedge; returns at a negedge with cmd_valid still asserted.
   task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
      int n;
      logic [31:0] pre;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accept_bound", 32'(n < 100), 1);
      pre = m_hash;
      @(posedge clk);
      @(negedge clk);
      model_cmd(op, d);
      if (op != 2'b01) begin
         n = 0;
         while (!cmd_ready && n < 20) begin
            check("mul_hold_hash", hash, pre);
            check("mul_busy", 32'(busy), 1);
            @(negedge clk);
            n++;
         end
         check("ready_low_cycles", n, (op == 2'b00) ? MUL_LAT : 0);
         check("hash_idle", hash, m_hash);
      end
   endtask

   // mode 0 random out_ready, 1 fixed pattern, 2 always ready; stops after nstop handshakes.
   task automatic drain(input int mode, input int nstop);
      int got, cyc, pidx;
      logic [7:0] prev_b;
      logic prev_stall;
      logic rdy;
      logic [31:0] dig;
      got = 0; cyc = 0; pidx = 0; prev_stall = 1'b0; prev_b = 8'h00; dig = 32'h0;
      check("out_valid_first", 32'(out_valid), 1);
      while (got < nstop && cyc < 200) begin
         if (mode == 1) begin
            rdy = pat[pidx % 7];
            pidx++;
         end else if (mode == 2) begin
            rdy = 1'b1;
         end else begin
            rdy = 1'($urandom_range(0, 1));
         end
         out_ready = rdy;
         check("cmd_ready_in_out", 32'(cmd_ready), 0);
         check("out_valid", 32'(out_valid), 1);
         if (prev_stall) check("stall_stable", out_byte, prev_b);
         check("out_byte", out_byte, exp_q[0]);
         check("out_last", 32'(out_last), 32'(got == 3));
         prev_b = out_byte;
         prev_stall = !rdy;
         @(posedge clk);
         if (rdy) begin
            dig = {dig[23:0], prev_b};
            void'(exp_q.pop_front());
            got++;
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      check("drain_bound", got, nstop);
      if (nstop == 4) begin
         check("post_out_valid", 32'(out_valid), 0);
         check("post_out_last", 32'(out_last), 0);
         check("post_cmd_ready", 32'(cmd_ready), 1);
         check("post_busy", 32'(busy), 0);
         check("post_hash", hash, OB);
         last_digest = dig;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_byte", out_byte, 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_hash", hash, OB);
      cmd_valid = 1'b0;
      out_ready = 1'b0;
      m_hash = OB;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic finish_and_drain(input int mode);
      send_cmd(2'b01, 8'h00);
      cmd_valid = 1'b0;
      drain(mode, 4);
   endtask

   initial begin
      int op_sel;
      @(negedge clk);
      do_reset();

      finish_and_drain(2);
      check("digest_empty", last_digest, OB);

      send_cmd(2'b00, 8'h61);
      finish_and_drain(2);
      check("digest_a", last_digest, 32'hE40C292C);

      for (int i = 0; i < 6; i++) send_cmd(2'b00, foobar[i]);
      finish_and_drain(0);
      check("digest_foobar", last_digest, 32'hBF9CF968);

      send_cmd(2'b00, 8'($urandom));
      send_cmd(2'b01, 8'h00);
      drain(1, 4);
      send_cmd(2'b01, 8'h00);
      cmd_valid = 1'b0;
      drain(2, 4);
      check("digest_after_bp", last_digest, OB);

      send_cmd(2'b00, 8'h61);
      send_cmd(2'b10, 8'h00);
      finish_and_drain(2);
      check("digest_clear", last_digest, OB);
      send_cmd(2'b00, 8'h12);
      send_cmd(2'b11, 8'hFF);
      finish_and_drain(0);
      check("digest_op11", last_digest, (OB ^ 32'h12) * PRIME);

      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h61;
      @(posedge clk);
      repeat (3) @(negedge clk);
      cmd_valid = 1'b0;
      do_reset();
      finish_and_drain(2);
      check("digest_rst_mul", last_digest, OB);

      send_cmd(2'b00, 8'h61);
      send_cmd(2'b01, 8'h00);
      cmd_valid = 1'b0;
      drain(2, 2);
      do_reset();
      finish_and_drain(2);
      check("digest_rst_out", last_digest, OB);

      for (int k = 0; k < 60; k++) begin
         op_sel = $urandom_range(0, 9);
         if (op_sel < 6)       send_cmd(2'b00, 8'($urandom));
         else if (op_sel == 6) send_cmd(2'b10, 8'($urandom));
         else if (op_sel == 7) send_cmd(2'b11, 8'($urandom));
         else                  finish_and_drain(0);
         if ($urandom_range(0, 3) == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      finish_and_drain(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
